// File: rtl/barrett_batch_ctrl.sv
// -----------------------------------------------------------------------------
// barrett_batch_ctrl
//
// Batch sequencer for an external Barrett reducer. Operands are gathered into
// a buffer while idle. A start launches the batch: one operand is issued per
// cycle, and results are collected in issue order into a result RAM that can
// be read back combinationally. The modulus, mu and the modulus bit length are
// held on registered outputs for the reducer.
//
// Ports
//   clk_i, rst_i          clock, synchronous active-high reset
//   cfg_we_i              load cfg_m_i / cfg_mu_i (idle only)
//   cfg_m_i, cfg_mu_i     modulus and precomputed Barrett mu
//   wr_en_i, wr_data_i    append an operand to the batch buffer (idle only)
//   clr_i                 empty the batch buffer (idle only)
//   start_i               launch the batch (idle only)
//   rd_addr_i, rd_data_o  result readback, combinational
//   count_o               operands currently buffered
//   busy_o                high while issuing or draining
//   done_o                one-cycle batch-complete pulse
//   err_o                 sticky error: overflow, stray valid or drain timeout
//   dp_start_o, dp_x_o    issue strobe and operand to the reducer
//   dp_m_o, dp_mu_o       registered modulus and mu
//   dp_m_bl_o             bit length of the registered modulus
//   dp_result_i           reducer result, returned in issue order
//   dp_valid_i            reducer result valid
// -----------------------------------------------------------------------------
module barrett_batch_ctrl #(
   parameter int WIDTH   = 64,
   parameter int DEPTH   = 64,
   parameter int TIMEOUT = 1024
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     cfg_we_i,
   input  logic [WIDTH-1:0]         cfg_m_i,
   input  logic [WIDTH-1:0]         cfg_mu_i,
   input  logic                     wr_en_i,
   input  logic [WIDTH-1:0]         wr_data_i,
   input  logic                     clr_i,
   input  logic                     start_i,
   input  logic [$clog2(DEPTH)-1:0] rd_addr_i,
   output logic [WIDTH-1:0]         rd_data_o,
   output logic [$clog2(DEPTH):0]   count_o,
   output logic                     busy_o,
   output logic                     done_o,
   output logic                     err_o,
   output logic                     dp_start_o,
   output logic [WIDTH-1:0]         dp_x_o,
   output logic [WIDTH-1:0]         dp_m_o,
   output logic [WIDTH-1:0]         dp_mu_o,
   output logic [WIDTH-1:0]         dp_m_bl_o,
   input  logic [WIDTH-1:0]         dp_result_i,
   input  logic                     dp_valid_i
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
   localparam logic [CW-1:0] ONE_C    = {{(CW-1){1'b0}}, 1'b1};
   localparam logic [CW-1:0] ZERO_C   = {CW{1'b0}};
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
   localparam logic [TW-1:0] TMO_ZERO = {TW{1'b0}};

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_e;

   // Index of the highest set bit plus one; zero for a zero modulus.
   function automatic logic [WIDTH-1:0] bit_len(input logic [WIDTH-1:0] v);
      logic [WIDTH-1:0] n;
      n = {WIDTH{1'b0}};
      for (int i = 0; i < WIDTH; i++) begin
         if (v[i]) begin
            n = WIDTH'(i + 1);
         end else begin
            n = n;
         end
      end
      return n;
   endfunction

   state_e            state_q;
   logic [CW-1:0]     count_q;
   logic [CW-1:0]     issue_q;
   logic [CW-1:0]     recv_q;
   logic [TW-1:0]     tmo_q;
   logic              busy_q;
   logic              done_q;
   logic              err_q;
   logic              dp_start_q;
   logic [WIDTH-1:0]  dp_x_q;
   logic [WIDTH-1:0]  m_q;
   logic [WIDTH-1:0]  mu_q;
   logic [WIDTH-1:0]  bl_q;

   logic [WIDTH-1:0]  buf_mem [DEPTH];
   logic [WIDTH-1:0]  res_mem [DEPTH];

   logic              idle_s;
   logic              active_s;
   logic              start_acc_s;
   logic              cfg_acc_s;
   logic              clr_acc_s;
   logic              wr_req_s;
   logic              wr_acc_s;
   logic              wr_drop_s;
   logic              recv_acc_s;
   logic              recv_bad_s;
   logic              recv_last_s;
   logic              issue_last_s;
   logic [CW-1:0]     issue_nxt_s;
   logic              timeout_s;
   logic              err_set_s;

   // Decode which requests are accepted this cycle. A start in idle takes
   // priority over a same-cycle clear or write, which are then dropped.
   always_comb begin
      idle_s       = (state_q == S_IDLE);
      active_s     = (state_q == S_ISSUE) || (state_q == S_DRAIN);
      start_acc_s  = idle_s && start_i;
      cfg_acc_s    = idle_s && cfg_we_i;
      clr_acc_s    = idle_s && !start_i && clr_i;
      wr_req_s     = idle_s && !start_i && !clr_i && wr_en_i;
      wr_acc_s     = wr_req_s && (count_q < DEPTH_C);
      wr_drop_s    = wr_req_s && (count_q >= DEPTH_C);
      recv_acc_s   = active_s && dp_valid_i && (recv_q != count_q);
      recv_bad_s   = dp_valid_i && !recv_acc_s;
      recv_last_s  = recv_acc_s && ((recv_q + ONE_C) == count_q);
      issue_nxt_s  = issue_q + ONE_C;
      issue_last_s = (issue_nxt_s == count_q);
      timeout_s    = (state_q == S_DRAIN) && !recv_acc_s && (tmo_q == TMO_LAST);
      err_set_s    = wr_drop_s || recv_bad_s || timeout_s;
   end

   // Operand buffer write port; contents survive reset undefined
   always_ff @(posedge clk_i) begin
      if (wr_acc_s) begin
         buf_mem[count_q[AW-1:0]] <= wr_data_i;
      end
   end

   // Result RAM write port, filled in reducer return order
   always_ff @(posedge clk_i) begin
      if (recv_acc_s) begin
         res_mem[recv_q[AW-1:0]] <= dp_result_i;
      end
   end

   // Batch sequencer with registered status and reducer-facing outputs
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= S_IDLE;
         count_q    <= ZERO_C;
         issue_q    <= ZERO_C;
         recv_q     <= ZERO_C;
         tmo_q      <= TMO_ZERO;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         dp_start_q <= 1'b0;
         dp_x_q     <= {WIDTH{1'b0}};
         m_q        <= {WIDTH{1'b0}};
         mu_q       <= {WIDTH{1'b0}};
         bl_q       <= {WIDTH{1'b0}};
      end else begin
         done_q     <= 1'b0;
         dp_start_q <= 1'b0;

         // A new error in the same cycle as an accepted start still sticks.
         if (err_set_s) begin
            err_q <= 1'b1;
         end else if (start_acc_s) begin
            err_q <= 1'b0;
         end

         // Configuration lands at the same edge as a start, so the launched
         // batch already sees the new modulus on dp_m_o.
         if (cfg_acc_s) begin
            m_q  <= cfg_m_i;
            mu_q <= cfg_mu_i;
            bl_q <= bit_len(cfg_m_i);
         end

         case (state_q)
            S_IDLE: begin
               if (start_acc_s) begin
                  issue_q <= ZERO_C;
                  recv_q  <= ZERO_C;
                  tmo_q   <= TMO_ZERO;
                  if (count_q == ZERO_C) begin
                     state_q <= S_DONE;
                     busy_q  <= 1'b0;
                  end else begin
                     state_q    <= S_ISSUE;
                     busy_q     <= 1'b1;
                     dp_start_q <= 1'b1;
                     dp_x_q     <= buf_mem[0];
                  end
               end else if (clr_acc_s) begin
                  count_q <= ZERO_C;
               end else if (wr_acc_s) begin
                  count_q <= count_q + ONE_C;
               end
            end

            S_ISSUE: begin
               if (recv_acc_s) begin
                  recv_q <= recv_q + ONE_C;
               end
               // Zero-latency reducers can complete the batch while issuing.
               if (recv_last_s) begin
                  state_q <= S_DONE;
                  busy_q  <= 1'b0;
               end else if (issue_last_s) begin
                  state_q <= S_DRAIN;
                  tmo_q   <= TMO_ZERO;
               end else begin
                  issue_q    <= issue_nxt_s;
                  dp_start_q <= 1'b1;
                  dp_x_q     <= buf_mem[issue_nxt_s[AW-1:0]];
               end
            end

            S_DRAIN: begin
               if (recv_acc_s) begin
                  recv_q <= recv_q + ONE_C;
               end
               if (recv_last_s || timeout_s) begin
                  state_q <= S_DONE;
                  busy_q  <= 1'b0;
               end else if (recv_acc_s) begin
                  tmo_q <= TMO_ZERO;
               end else begin
                  tmo_q <= tmo_q + {{(TW-1){1'b0}}, 1'b1};
               end
            end

            S_DONE: begin
               done_q  <= 1'b1;
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end

            default: begin
               state_q <= S_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign rd_data_o  = res_mem[rd_addr_i];
   assign count_o    = count_q;
   assign busy_o     = busy_q;
   assign done_o     = done_q;
   assign err_o      = err_q;
   assign dp_start_o = dp_start_q;
   assign dp_x_o     = dp_x_q;
   assign dp_m_o     = m_q;
   assign dp_mu_o    = mu_q;
   assign dp_m_bl_o  = bl_q;

endmodule

// File: tb/tb_barrett_batch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_barrett_batch_ctrl
//
// Directed bench for barrett_batch_ctrl with a four-stage reducer model that
// returns x mod m in issue order. Expected values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_barrett_batch_ctrl;

   localparam logic [63:0] M    = 64'h3A32E4C4C7A8C21B;
   localparam logic [63:0] MU   = 64'h466123E72A6BDD53;
   localparam logic [63:0] X2   = 64'h3A32E4C4C7A8C21C;
   localparam logic [63:0] XMAX = 64'hFFFFFFFFFFFFFFFF;
   localparam logic [63:0] RMAX = 64'h17346CECE15CF793;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic        cfg_we_i = 1'b0;
   logic [63:0] cfg_m_i = 64'd0;
   logic [63:0] cfg_mu_i = 64'd0;
   logic        wr_en_i = 1'b0;
   logic [63:0] wr_data_i = 64'd0;
   logic        clr_i = 1'b0;
   logic        start_i = 1'b0;
   logic [5:0]  rd_addr_i = 6'd0;
   logic [63:0] rd_data_o;
   logic [6:0]  count_o;
   logic        busy_o;
   logic        done_o;
   logic        err_o;
   logic        dp_start_o;
   logic [63:0] dp_x_o;
   logic [63:0] dp_m_o;
   logic [63:0] dp_mu_o;
   logic [63:0] dp_m_bl_o;
   logic [63:0] dp_result_i;
   logic        dp_valid_i;

   logic        red_en = 1'b1;
   logic        inj_valid = 1'b0;
   logic [3:0]  pv = 4'b0000;
   logic [63:0] px [4];

   int n_chk  = 0;
   int n_pass = 0;
   int n_st, first, last, done_at, n_done;

   barrett_batch_ctrl #(
      .WIDTH   (64),
      .DEPTH   (64),
      .TIMEOUT (16)
   ) dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .cfg_we_i    (cfg_we_i),
      .cfg_m_i     (cfg_m_i),
      .cfg_mu_i    (cfg_mu_i),
      .wr_en_i     (wr_en_i),
      .wr_data_i   (wr_data_i),
      .clr_i       (clr_i),
      .start_i     (start_i),
      .rd_addr_i   (rd_addr_i),
      .rd_data_o   (rd_data_o),
      .count_o     (count_o),
      .busy_o      (busy_o),
      .done_o      (done_o),
      .err_o       (err_o),
      .dp_start_o  (dp_start_o),
      .dp_x_o      (dp_x_o),
      .dp_m_o      (dp_m_o),
      .dp_mu_o     (dp_mu_o),
      .dp_m_bl_o   (dp_m_bl_o),
      .dp_result_i (dp_result_i),
      .dp_valid_i  (dp_valid_i)
   );

   always #5 clk_i = ~clk_i;

   // Reducer model: fixed latency of four cycles from issue to valid
   always @(posedge clk_i) begin
      pv    <= {pv[2:0], dp_start_o};
      px[0] <= (dp_m_o != 64'd0) ? (dp_x_o % dp_m_o) : dp_x_o;
      px[1] <= px[0];
      px[2] <= px[1];
      px[3] <= px[2];
   end

   assign dp_valid_i  = (pv[3] & red_en) | inj_valid;
   assign dp_result_i = px[3];

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic write_op(input logic [63:0] x);
      wr_en_i   = 1'b1;
      wr_data_i = x;
      tick();
      wr_en_i   = 1'b0;
   endtask

   // Start a batch and watch a bounded window; cycle 1 is the first after start.
   // With poke set, cfg/wr/clr are pulsed during cycle 1 while the block is busy.
   task automatic run_batch(input bit poke, output int ns, output int f, output int l,
                            output int da, output int nd);
      ns = 0; f = -1; l = -1; da = -1; nd = 0;
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
      if (poke) begin
         cfg_we_i  = 1'b1;
         cfg_m_i   = 64'd5;
         wr_en_i   = 1'b1;
         wr_data_i = 64'd9;
         clr_i     = 1'b1;
      end
      for (int c = 1; c <= 120; c++) begin
         if (c == 2) begin
            cfg_we_i = 1'b0;
            wr_en_i  = 1'b0;
            clr_i    = 1'b0;
         end
         if (dp_start_o) begin
            ns++;
            if (f < 0) f = c;
            l = c;
         end
         if (done_o) begin
            nd++;
            if (da < 0) da = c;
         end
         tick();
      end
   endtask

   initial begin
      // Reset long enough to flush X out of the reducer model
      for (int i = 0; i < 6; i++) tick();
      rst_i = 1'b0;
      tick();
      chk("rst_busy", {63'd0, busy_o}, 64'd0);
      chk("rst_done", {63'd0, done_o}, 64'd0);
      chk("rst_err", {63'd0, err_o}, 64'd0);
      chk("rst_count", {57'd0, count_o}, 64'd0);
      chk("rst_dp_start", {63'd0, dp_start_o}, 64'd0);
      chk("rst_dp_m", dp_m_o, 64'd0);
      chk("rst_dp_bl", dp_m_bl_o, 64'd0);

      // Configuration
      cfg_we_i = 1'b1; cfg_m_i = M; cfg_mu_i = MU;
      tick();
      cfg_we_i = 1'b0;
      chk("cfg_bl", dp_m_bl_o, 64'd62);
      chk("cfg_m", dp_m_o, M);
      chk("cfg_mu", dp_mu_o, MU);

      // Three-operand batch, reducer latency 4
      write_op(64'd1);
      write_op(X2);
      write_op(XMAX);
      chk("b3_count", {57'd0, count_o}, 64'd3);
      run_batch(1'b0, n_st, first, last, done_at, n_done);
      chk("b3_nstart", 64'(n_st), 64'd3);
      chk("b3_first", 64'(first), 64'd1);
      chk("b3_last", 64'(last), 64'd3);
      chk("b3_done_at", 64'(done_at), 64'd9);
      chk("b3_ndone", 64'(n_done), 64'd1);
      chk("b3_busy", {63'd0, busy_o}, 64'd0);
      chk("b3_err", {63'd0, err_o}, 64'd0);
      rd_addr_i = 6'd0; #1; chk("b3_res0", rd_data_o, 64'd1);
      rd_addr_i = 6'd1; #1; chk("b3_res1", rd_data_o, 64'd1);
      rd_addr_i = 6'd2; #1; chk("b3_res2", rd_data_o, RMAX);
      chk("b3_count_kept", {57'd0, count_o}, 64'd3);

      // Empty batch
      clr_i = 1'b1;
      tick();
      clr_i = 1'b0;
      chk("e_count", {57'd0, count_o}, 64'd0);
      run_batch(1'b0, n_st, first, last, done_at, n_done);
      chk("e_nstart", 64'(n_st), 64'd0);
      chk("e_done_at", 64'(done_at), 64'd2);
      chk("e_ndone", 64'(n_done), 64'd1);
      chk("e_err", {63'd0, err_o}, 64'd0);

      // Overflow: 65 writes into 64 entries
      for (int i = 0; i < 65; i++) write_op(64'h100 + 64'(i));
      chk("ov_count", {57'd0, count_o}, 64'd64);
      chk("ov_err", {63'd0, err_o}, 64'd1);
      run_batch(1'b0, n_st, first, last, done_at, n_done);
      chk("ov_nstart", 64'(n_st), 64'd64);
      chk("ov_first", 64'(first), 64'd1);
      chk("ov_last", 64'(last), 64'd64);
      chk("ov_done_at", 64'(done_at), 64'd70);
      chk("ov_err_cleared", {63'd0, err_o}, 64'd0);
      rd_addr_i = 6'd0;  #1; chk("ov_res0", rd_data_o, 64'h100);
      rd_addr_i = 6'd31; #1; chk("ov_res31", rd_data_o, 64'h11F);
      rd_addr_i = 6'd63; #1; chk("ov_res63", rd_data_o, 64'h13F);

      // Reset during drain with two results still outstanding
      clr_i = 1'b1;
      tick();
      clr_i = 1'b0;
      write_op(64'd2);
      write_op(64'd3);
      write_op(64'd4);
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
      for (int i = 0; i < 5; i++) tick();
      chk("rd_busy_before", {63'd0, busy_o}, 64'd1);
      rst_i = 1'b1;
      tick();
      rst_i = 1'b0;
      chk("rd_busy_after", {63'd0, busy_o}, 64'd0);
      chk("rd_count", {57'd0, count_o}, 64'd0);
      chk("rd_err_clear", {63'd0, err_o}, 64'd0);
      tick();
      chk("rd_late_err", {63'd0, err_o}, 64'd1);
      chk("rd_late_count", {57'd0, count_o}, 64'd0);
      chk("rd_late_busy", {63'd0, busy_o}, 64'd0);

      // Drain timeout with a silent reducer; busy-time requests are ignored
      cfg_we_i = 1'b1; cfg_m_i = M; cfg_mu_i = MU;
      tick();
      cfg_we_i = 1'b0;
      red_en = 1'b0;
      write_op(64'd7);
      run_batch(1'b1, n_st, first, last, done_at, n_done);
      chk("to_nstart", 64'(n_st), 64'd1);
      chk("to_done_at", 64'(done_at), 64'd19);
      chk("to_ndone", 64'(n_done), 64'd1);
      chk("to_err", {63'd0, err_o}, 64'd1);
      chk("to_busy", {63'd0, busy_o}, 64'd0);
      chk("busy_cfg_ignored", dp_m_o, M);
      chk("busy_wr_clr_ignored", {57'd0, count_o}, 64'd1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/barrett_batch_ctrl.md
BARRETT_BATCH_CTRL -- requirements
Module: barrett_batch_ctrl

Interface
REQ-001 Parameters SHALL be: WIDTH, default 64, operand/result width; DEPTH, default 64, batch buffer entries; TIMEOUT, default 1024, maximum drain cycles.
REQ-002 clk_i  in  1  clock; single clock domain, rising edge.
REQ-003 rst_i  in  1  reset; synchronous, active-high.
REQ-004 cfg_we_i  in  1  load cfg_m_i/cfg_mu_i; honoured only in IDLE.
REQ-005 cfg_m_i / cfg_mu_i  in  WIDTH each  modulus / precomputed Barrett mu.
REQ-006 wr_en_i / wr_data_i  in  1 / WIDTH  append operand x to batch buffer.
REQ-007 clr_i  in  1  empty batch buffer (IDLE only).
REQ-008 start_i  in  1  launch batch (IDLE only).
REQ-009 rd_addr_i / rd_data_o  in / out  clog2(DEPTH) / WIDTH  result readback, combinational read.
REQ-010 count_o  out  clog2(DEPTH)+1  operands currently buffered.
REQ-011 busy_o / done_o / err_o  out  1 each  busy; batch-complete pulse; sticky error.
REQ-012 dp_start_o / dp_x_o  out  1 / WIDTH  issue strobe and operand to reducer.
REQ-013 dp_m_o / dp_mu_o / dp_m_bl_o  out  WIDTH each  registered modulus, mu, modulus bit length.
REQ-014 dp_result_i / dp_valid_i  in  WIDTH / 1  reducer result and valid, in issue order.

Function
REQ-015 FSM SHALL have states IDLE, ISSUE, DRAIN, DONE; busy_o=1 in ISSUE and DRAIN only.
REQ-016 cfg_we_i in IDLE SHALL register m, mu and dp_m_bl_o = index of highest set bit of m plus 1 (0 when m=0); values are held constant on dp_* outputs at all times.
REQ-017 wr_en_i in IDLE with count<DEPTH SHALL store at address count and increment count; when count=DEPTH it is dropped and err_o set.
REQ-018 wr_en_i, clr_i, cfg_we_i while busy_o=1 SHALL be ignored with no state change.
REQ-019 clr_i and wr_en_i in the same IDLE cycle: clr wins, count=0.
REQ-020 start_i in IDLE with count>0 SHALL move to ISSUE next cycle; issue and receive pointers reset to 0.
REQ-021 start_i in IDLE with count=0 SHALL go to DONE, with done_o pulsing the following cycle and no dp_start_o.
REQ-022 In ISSUE, dp_start_o=1 with dp_x_o=buffer[issue_ptr] each cycle, one operand per cycle, back-to-back; after issue_ptr reaches count-1 the FSM enters DRAIN.
REQ-023 Each dp_valid_i=1 in ISSUE or DRAIN SHALL write dp_result_i to result[recv_ptr] and increment recv_ptr.
REQ-024 When recv_ptr reaches count, the FSM SHALL enter DONE; this may happen straight from ISSUE if the reducer latency is 0.
REQ-025 DONE SHALL last one cycle with done_o=1, then return to IDLE; buffer contents, count and results are retained, so start_i reruns the same batch.
REQ-026 dp_valid_i in IDLE/DONE, or with recv_ptr=count, SHALL be ignored and set err_o.
REQ-027 A drain cycle counter (reset on each received valid) reaching TIMEOUT SHALL set err_o and force DONE.
REQ-028 err_o SHALL be cleared only by rst_i or by start_i being accepted.
REQ-029 start_i in the same cycle as cfg_we_i in IDLE: cfg is applied first, and the batch uses the new m/mu.
REQ-030 Throughput SHALL be count issue cycles plus reducer latency plus 2 cycles from start_i to done_o.

Reset
REQ-031 rst_i SHALL force IDLE, count=0, pointers=0, busy_o=0, done_o=0, err_o=0, dp_start_o=0, dp_x_o=0, dp_m_o=0, dp_mu_o=0, dp_m_bl_o=0; buffer/result RAM contents are undefined.
REQ-032 rst_i asserted mid-ISSUE/DRAIN SHALL abort the batch within that cycle, and late dp_valid_i after reset SHALL only set err_o.

Verification
REQ-033 cfg m=0x3A32E4C4C7A8C21B, mu=0x466123E72A6BDD53 -> dp_m_bl_o=62 next cycle.
REQ-034 Write 3 operands {0x1, 0x3A32E4C4C7A8C21C, 0xFFFFFFFFFFFFFFFF}, start, model reducer latency 4 -> dp_start_o high 3 consecutive cycles; results = {0x1, 0x1, 0xFFFF...FFFF mod m}; done_o one cycle; busy_o low after.
REQ-035 Write 65 operands with DEPTH=64 -> count_o=64, err_o=1; start processes 64 in order.
REQ-036 start with count=0 -> no dp_start_o, done_o pulse 2 cycles after start, err_o=0.
REQ-037 Reducer never asserts valid, TIMEOUT=16 -> err_o=1 and done_o after 16 drain cycles.
REQ-038 rst_i during DRAIN with 2 results outstanding -> IDLE next cycle, count_o=0; subsequent dp_valid_i sets err_o only.
